// File: rtl/word_unpacker.sv
// word_unpacker: splits 2*W-bit words into two W-bit bytes, MSB byte first, paced by en.
// Latency: a word accepted at edge k can emit its MSB byte at edge k+1; the LSB byte follows at the next en edge.
// Backpressure: one-deep pending buffer B; ready=0 while B is full; a load while ready=0 is dropped and sets sticky overrun.
// Optional feature macro UNPACK_PARITY_EN adds a registered even-parity output alongside data_out.
module word_unpacker #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [2*W-1:0] data_in,
  input  logic           en,
  output logic           ready,
  output logic [W-1:0]   data_out,
  output logic           valid_out,
`ifdef UNPACK_PARITY_EN
  output logic           parity_out,
`endif
  output logic           overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [2*W-1:0] h, h_nxt;
  logic [2*W-1:0] b, b_nxt;
  logic           b_full, b_full_nxt;
  logic [W-1:0]   dout_nxt;
  logic           vld_nxt;
  logic           accept;

  // ready depends only on registered state, so load never combinationally affects it
  assign ready  = ~b_full;
  assign accept = load & ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and datapath decode; everything holds unless a case overrides it
  always_comb begin
    state_nxt  = state;
    h_nxt      = h;
    b_nxt      = b;
    b_full_nxt = b_full;
    dout_nxt   = data_out;
    vld_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        // B is always empty here, so every load is accepted straight into H
        if (accept) begin
          h_nxt     = data_in;
          state_nxt = HI;
        end
      end
      HI: begin
        if (en) begin
          dout_nxt  = h[2*W-1:W];
          vld_nxt   = 1'b1;
          state_nxt = LO;
        end
        if (accept) begin
          b_nxt      = data_in;
          b_full_nxt = 1'b1;
        end
      end
      LO: begin
        if (en) begin
          dout_nxt = h[W-1:0];
          vld_nxt  = 1'b1;
          if (b_full) begin
            // pending word takes over; any load this edge sees ready=0 and is dropped
            h_nxt      = b;
            b_full_nxt = 1'b0;
            state_nxt  = HI;
          end else if (accept) begin
            // H frees up this edge, so bypass B entirely
            h_nxt     = data_in;
            state_nxt = HI;
          end else begin
            state_nxt = IDLE;
          end
        end else if (accept) begin
          b_nxt      = data_in;
          b_full_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: H, B, output byte and valid strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      h         <= '0;
      b         <= '0;
      b_full    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      h         <= h_nxt;
      b         <= b_nxt;
      b_full    <= b_full_nxt;
      data_out  <= dout_nxt;
      valid_out <= vld_nxt;
    end
  end

  // Sticky overrun: any load arriving while the pending buffer is full
  always_ff @(posedge clk) begin
    if (!rst)                overrun <= 1'b0;
    else if (load && !ready) overrun <= 1'b1;
  end

`ifdef UNPACK_PARITY_EN
  // Parity tracks data_out, updated only when a new byte is emitted
  always_ff @(posedge clk) begin
    if (!rst)         parity_out <= 1'b0;
    else if (vld_nxt) parity_out <= ^dout_nxt;
  end
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker: reset, single word, en gating, back-to-back, overrun, mid-word reset.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// With UNPACK_PARITY_EN defined the parity output is also checked on the final word.
module tb_word_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        en;
  logic        ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        overrun;
`ifdef UNPACK_PARITY_EN
  logic        parity_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_unpacker #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data_in   (data_in),
    .en        (en),
    .ready     (ready),
    .data_out  (data_out),
    .valid_out (valid_out),
`ifdef UNPACK_PARITY_EN
    .parity_out(parity_out),
`endif
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a byte emitted on the edge just taken
  task automatic chk_byte(input string tag, input logic [7:0] exp);
    chk({tag, ".vld"}, {15'd0, valid_out}, 16'd1);
    chk({tag, ".dat"}, {8'd0, data_out}, {8'd0, exp});
  endtask

  initial begin
    // Reset held two edges with a load pending: nothing may be accepted
    rst = 1'b0; load = 1'b1; data_in = 16'hFFFF; en = 1'b0;
    tick(); tick();
    chk("rst.dout",  {8'd0, data_out},   16'h0000);
    chk("rst.vld",   {15'd0, valid_out}, 16'h0000);
    chk("rst.ready", {15'd0, ready},     16'h0001);
    chk("rst.ovr",   {15'd0, overrun},   16'h0000);
    rst = 1'b1; load = 1'b0; en = 1'b1;
    tick();
    chk("rst.noword", {15'd0, valid_out}, 16'h0000);
    tick();
    chk("rst.noword2", {15'd0, valid_out}, 16'h0000);

    // Single word with en held high
    load = 1'b1; data_in = 16'hA5FF; en = 1'b1;
    tick();
    chk("single.k", {15'd0, valid_out}, 16'h0000);
    load = 1'b0;
    tick(); chk_byte("single.b0", 8'hA5);
    tick(); chk_byte("single.b1", 8'hFF);
    tick();
    chk("single.idle.vld",  {15'd0, valid_out}, 16'h0000);
    chk("single.idle.hold", {8'd0, data_out},   16'h00FF);
    tick();
    chk("single.idle2.vld", {15'd0, valid_out}, 16'h0000);

    // en gating 1,0,1
    load = 1'b1; data_in = 16'h1234; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); chk_byte("gate.b0", 8'h12);
    en = 1'b0;
    tick();
    chk("gate.gap.vld",  {15'd0, valid_out}, 16'h0000);
    chk("gate.gap.hold", {8'd0, data_out},   16'h0012);
    en = 1'b1;
    tick(); chk_byte("gate.b1", 8'h34);
    tick();
    chk("gate.end.vld", {15'd0, valid_out}, 16'h0000);

    // Back-to-back words, en high throughout
    en = 1'b1; load = 1'b1; data_in = 16'hA5FF;
    tick();
    chk("b2b.k.ready", {15'd0, ready}, 16'h0001);
    data_in = 16'h55AA;
    tick(); chk_byte("b2b.b0", 8'hA5);
    chk("b2b.k1.ready", {15'd0, ready}, 16'h0000);
    load = 1'b0;
    tick(); chk_byte("b2b.b1", 8'hFF);
    chk("b2b.k2.ready", {15'd0, ready}, 16'h0001);
    tick(); chk_byte("b2b.b2", 8'h55);
    tick(); chk_byte("b2b.b3", 8'hAA);
    chk("b2b.ovr", {15'd0, overrun}, 16'h0000);
    tick();
    chk("b2b.end.vld", {15'd0, valid_out}, 16'h0000);

    // Overrun: three loads with en low, third one dropped
    en = 1'b0; load = 1'b1; data_in = 16'h1111;
    tick();
    data_in = 16'h2222;
    tick();
    chk("ovr.ready0", {15'd0, ready}, 16'h0000);
    data_in = 16'h3333;
    tick();
    chk("ovr.flag",  {15'd0, overrun}, 16'h0001);
    chk("ovr.ready", {15'd0, ready},   16'h0000);
    load = 1'b0; en = 1'b1;
    tick(); chk_byte("ovr.b0", 8'h11);
    tick(); chk_byte("ovr.b1", 8'h11);
    tick(); chk_byte("ovr.b2", 8'h22);
    tick(); chk_byte("ovr.b3", 8'h22);
    tick();
    chk("ovr.nothird", {15'd0, valid_out}, 16'h0000);
    tick();
    chk("ovr.nothird2", {15'd0, valid_out}, 16'h0000);
    chk("ovr.sticky",   {15'd0, overrun},   16'h0001);

    // Mid-word reset: BE emitted, EF must never appear
    en = 1'b0; load = 1'b1; data_in = 16'hBEEF;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); chk_byte("mid.b0", 8'hBE);
    rst = 1'b0;
    tick();
    chk("mid.rst.dout",  {8'd0, data_out},   16'h0000);
    chk("mid.rst.vld",   {15'd0, valid_out}, 16'h0000);
    chk("mid.rst.ready", {15'd0, ready},     16'h0001);
    chk("mid.rst.ovr",   {15'd0, overrun},   16'h0000);
    rst = 1'b1;
    tick();
    chk("mid.noEF", {15'd0, valid_out}, 16'h0000);
    load = 1'b1; data_in = 16'h0102;
    tick();
    load = 1'b0;
    tick(); chk_byte("mid.b1", 8'h01);
`ifdef UNPACK_PARITY_EN
    chk("mid.par0", {15'd0, parity_out}, 16'h0001);
`endif
    tick(); chk_byte("mid.b2", 8'h02);
`ifdef UNPACK_PARITY_EN
    chk("mid.par1", {15'd0, parity_out}, 16'h0001);
`endif
    tick();
    chk("mid.end.vld", {15'd0, valid_out}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Downstream consumer of the 8-bit-to-16-bit decimator. Accepts 16-bit words on the decimator's `load_R0` strobe.
- Re-serialises each word to two bytes, MSB byte first, paced by an `en` strobe.
- Holds one active word plus a one-deep pending buffer, so a back-to-back word is absorbed without a stall.
- Split into a controller (FSM) and a datapath (holding register H, pending register B, output register).

Parameters:
- W, 8, output byte width; the input word is 2*W bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset; synchronous, active-low; sampled on rising clk
- load  input  1  word strobe; data_in is accepted when load=1 and ready=1
- data_in  input  2*W  word to unpack; data_in[2W-1:W] is the MSB byte
- en  input  1  emit enable; one byte is emitted per clock edge with en=1 and a word held
- ready  output  1  =1 when B is empty; decoded from registered state only, no input-to-output path
- data_out  output  W  registered output byte
- valid_out  output  1  registered; 1 for exactly the cycle after a byte is emitted
- overrun  output  1  sticky flag; set when load=1 arrives while ready=0

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, H=0, B empty, data_out=0, valid_out=0, overrun=0.
  - ready=1 from that point on.
  - Reset mid-word discards H and B without emitting anything.
- States:
  - IDLE: no word held.
  - HI: H held, MSB byte pending.
  - LO: LSB byte pending.
- IDLE:
  - load accepted → H<=data_in, go to HI.
  - en is ignored; valid_out=0.
- HI:
  - en=1 → data_out<=H[2W-1:W], valid_out<=1, go to LO.
  - en=0 → hold state, valid_out<=0.
- LO:
  - en=1 → data_out<=H[W-1:0], valid_out<=1, then:
    - if B is full: H<=B, B<=empty, go to HI;
    - else if load is accepted this edge: H<=data_in directly, go to HI;
    - else go to IDLE.
  - en=0 → hold state, valid_out<=0.
- Load while a word is held (HI or LO):
  - If B is empty, B<=data_in.
  - Exception: in LO with en=1 and B empty, the word goes straight to H as above and never enters B.
- Load while ready=0: the word is dropped and overrun<=1. This applies even if B drains on the same edge, because ready is registered.
- overrun clears only on reset.
- data_out holds its last value whenever valid_out=0.
- Latency:
  - load accepted at edge k → MSB byte at the earliest edge k+1 (needs en=1 at k+1).
  - LSB byte at the next edge with en=1.
- Throughput: one byte per en cycle. A continuous stream of loads every other cycle with en=1 yields a gapless byte stream.

Optional Feature:
- Macro: UNPACK_PARITY_EN.
- Defined:
  - Adds output port parity_out (1 bit), registered and updated on the same edge as data_out.
  - parity_out = even parity of the new byte (XOR reduction).
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with load=1 and data_in=16'hFFFF → data_out=0, valid_out=0, ready=1, overrun=0; no word accepted.
- Single word: load 16'hA5FF, en=1 continuously → valid_out high for 2 consecutive cycles with data_out=8'hA5 then 8'hFF; then valid_out=0 and state IDLE.
- en gating: load 16'h1234, then en sequence 1,0,1 → 8'h12, one cycle with valid_out=0 and data_out held at 8'h12, then 8'h34.
- Back-to-back: load 16'hA5FF at edge k and 16'h55AA at edge k+1, en=1 throughout →
  - bytes A5,FF,55,AA on edges k+1..k+4 with no gap;
  - ready=0 only between edges k+1 and k+2;
  - overrun stays 0.
- Overrun: en=0, load 16'h1111, 16'h2222, 16'h3333 on 3 consecutive edges →
  - third word dropped; ready=0; overrun=1.
  - Then en=1 → bytes 11,11,22,22 only; overrun remains 1 until reset.
- Mid-operation reset: load 16'hBEEF, emit 8'hBE, assert rst=0 for 1 cycle →
  - no 8'hEF is emitted; outputs return to reset values.
  - A subsequent load of 16'h0102 emits 01,02.
  - With UNPACK_PARITY_EN defined, parity_out reads 1,1.
